// File: rtl/video_mnist_pkg.sv
// rtl/video_mnist_pkg.sv - shared defaults and width helpers for the MNIST class-vote output stage
package video_mnist_pkg;

    localparam int DEFAULT_CLASS_NUM = 10;
    localparam int DEFAULT_VOTE_BITS = 8;

    // Width needed to hold a popcount of 0..vote_bits
    function automatic int score_width(input int vote_bits);
        return $clog2(vote_bits + 1);
    endfunction

    // Width needed to hold class indices 0..class_num (class_num itself is the reject code)
    function automatic int class_width(input int class_num);
        return $clog2(class_num + 1);
    endfunction

    // The reject result is encoded as the first index past the last real class
    function automatic int reject_code(input int class_num);
        return class_num;
    endfunction

endpackage

// File: rtl/video_mnist_popcount.sv
// rtl/video_mnist_popcount.sv - combinational popcount of one class vote group
module video_mnist_popcount
    import video_mnist_pkg::*;
#(
    parameter int VOTE_BITS   = DEFAULT_VOTE_BITS,
    parameter int SCORE_WIDTH = score_width(VOTE_BITS)
) (
    input  logic [VOTE_BITS-1:0]   votes,
    output logic [SCORE_WIDTH-1:0] score
);

    // Count the set votes of this class
    always_comb begin
        score = '0;
        for (int i = 0; i < VOTE_BITS; i++) begin
            score = score + SCORE_WIDTH'(votes[i]);
        end
    end

endmodule

// File: rtl/video_mnist_class_vote.sv
// rtl/video_mnist_class_vote.sv - popcount/argmax/threshold class vote stage; optional VIDEO_MNIST_CLASS_VOTE_FRAME_STATS_EN adds per-frame reject stats
module video_mnist_class_vote
    import video_mnist_pkg::*;
#(
    parameter int TUSER_WIDTH   = 1,
    parameter int CLASS_NUM     = DEFAULT_CLASS_NUM,
    parameter int VOTE_BITS     = DEFAULT_VOTE_BITS,
    parameter int S_TDATA_WIDTH = CLASS_NUM * VOTE_BITS,
    parameter int SCORE_WIDTH   = score_width(VOTE_BITS),
    parameter int CLASS_WIDTH   = class_width(CLASS_NUM),
    parameter int M_TDATA_WIDTH = CLASS_WIDTH + SCORE_WIDTH
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [SCORE_WIDTH-1:0]   param_threshold,
    input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
    input  logic                     s_axi4s_tlast,
    input  logic [S_TDATA_WIDTH-1:0] s_axi4s_tdata,
    input  logic                     s_axi4s_tvalid,
    output logic                     s_axi4s_tready,
    output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
    output logic                     m_axi4s_tlast,
    output logic [M_TDATA_WIDTH-1:0] m_axi4s_tdata,
    output logic                     m_axi4s_tvalid,
`ifdef VIDEO_MNIST_CLASS_VOTE_FRAME_STATS_EN
    output logic [31:0]              stat_reject_count,
    output logic [31:0]              stat_frame_count,
`endif
    input  logic                     m_axi4s_tready
);

    localparam logic [CLASS_WIDTH-1:0] REJECT_CLASS = CLASS_WIDTH'(reject_code(CLASS_NUM));

    // The whole pipeline advances together whenever the output slot is free or draining
    logic cke;
    assign cke            = m_axi4s_tready | ~m_axi4s_tvalid;
    assign s_axi4s_tready = cke & aresetn;

    // Stage 1: per-class popcount
    logic [SCORE_WIDTH-1:0] pop      [CLASS_NUM];
    logic [SCORE_WIDTH-1:0] s1_score [CLASS_NUM];
    logic                   s1_valid;
    logic [TUSER_WIDTH-1:0] s1_user;
    logic                   s1_last;

    for (genvar c = 0; c < CLASS_NUM; c++) begin : g_pop
        video_mnist_popcount #(
            .VOTE_BITS   (VOTE_BITS),
            .SCORE_WIDTH (SCORE_WIDTH)
        ) u_popcount (
            .votes (s_axi4s_tdata[c*VOTE_BITS +: VOTE_BITS]),
            .score (pop[c])
        );
    end

    // Capture class scores with their sideband
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid <= 1'b0;
            s1_user  <= '0;
            s1_last  <= 1'b0;
            for (int c = 0; c < CLASS_NUM; c++) begin
                s1_score[c] <= '0;
            end
        end else if (cke) begin
            s1_valid <= s_axi4s_tvalid;
            s1_user  <= s_axi4s_tuser;
            s1_last  <= s_axi4s_tlast;
            for (int c = 0; c < CLASS_NUM; c++) begin
                s1_score[c] <= pop[c];
            end
        end
    end

    // Stage 2: argmax with strict greater-than so the lowest index wins ties
    logic [CLASS_WIDTH-1:0] arg_idx;
    logic [SCORE_WIDTH-1:0] arg_max;

    always_comb begin
        arg_idx = '0;
        arg_max = s1_score[0];
        for (int c = 1; c < CLASS_NUM; c++) begin
            if (s1_score[c] > arg_max) begin
                arg_max = s1_score[c];
                arg_idx = CLASS_WIDTH'(c);
            end
        end
    end

    logic                   s2_valid;
    logic [CLASS_WIDTH-1:0] s2_idx;
    logic [SCORE_WIDTH-1:0] s2_max;
    logic                   s2_reject;
    logic [TUSER_WIDTH-1:0] s2_user;
    logic                   s2_last;

    // Register the winner and its threshold test against the live threshold
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s2_valid  <= 1'b0;
            s2_idx    <= '0;
            s2_max    <= '0;
            s2_reject <= 1'b0;
            s2_user   <= '0;
            s2_last   <= 1'b0;
        end else if (cke) begin
            s2_valid  <= s1_valid;
            s2_idx    <= arg_idx;
            s2_max    <= arg_max;
            s2_reject <= (arg_max < param_threshold);
            s2_user   <= s1_user;
            s2_last   <= s1_last;
        end
    end

    // Stage 3: substitute the reject code and present the result
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axi4s_tvalid <= 1'b0;
            m_axi4s_tdata  <= '0;
            m_axi4s_tuser  <= '0;
            m_axi4s_tlast  <= 1'b0;
        end else if (cke) begin
            m_axi4s_tvalid <= s2_valid;
            m_axi4s_tdata  <= {s2_max, (s2_reject ? REJECT_CLASS : s2_idx)};
            m_axi4s_tuser  <= s2_user;
            m_axi4s_tlast  <= s2_last;
        end
    end

`ifdef VIDEO_MNIST_CLASS_VOTE_FRAME_STATS_EN
    logic        out_hs;
    logic        out_reject;
    logic [31:0] reject_run;

    assign out_hs     = m_axi4s_tvalid & m_axi4s_tready;
    assign out_reject = (m_axi4s_tdata[CLASS_WIDTH-1:0] == REJECT_CLASS);

    // Count rejects per frame; a frame start closes the previous frame's tally
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            reject_run        <= '0;
            stat_reject_count <= '0;
            stat_frame_count  <= '0;
        end else if (out_hs) begin
            if (m_axi4s_tuser[0]) begin
                stat_reject_count <= reject_run;
                reject_run        <= 32'(out_reject);
                stat_frame_count  <= stat_frame_count + 32'd1;
            end else if (out_reject) begin
                reject_run <= reject_run + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_video_mnist_class_vote.sv
// tb/tb_video_mnist_class_vote.sv - randomized self-checking bench for video_mnist_class_vote
module tb_video_mnist_class_vote;

    localparam int CN  = 10;
    localparam int VB  = 8;
    localparam int SW  = 4;
    localparam int CW  = 4;
    localparam int MW  = CW + SW;
    localparam int SDW = CN * VB;

    logic           aclk = 1'b0;
    logic           aresetn = 1'b0;
    logic [SW-1:0]  param_threshold = '0;
    logic [0:0]     s_axi4s_tuser = '0;
    logic           s_axi4s_tlast = 1'b0;
    logic [SDW-1:0] s_axi4s_tdata = '0;
    logic           s_axi4s_tvalid = 1'b0;
    logic           s_axi4s_tready;
    logic [0:0]     m_axi4s_tuser;
    logic           m_axi4s_tlast;
    logic [MW-1:0]  m_axi4s_tdata;
    logic           m_axi4s_tvalid;
    logic           m_axi4s_tready = 1'b0;
`ifdef VIDEO_MNIST_CLASS_VOTE_FRAME_STATS_EN
    logic [31:0]    stat_reject_count;
    logic [31:0]    stat_frame_count;
`endif

    video_mnist_class_vote dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .param_threshold (param_threshold),
        .s_axi4s_tuser   (s_axi4s_tuser),
        .s_axi4s_tlast   (s_axi4s_tlast),
        .s_axi4s_tdata   (s_axi4s_tdata),
        .s_axi4s_tvalid  (s_axi4s_tvalid),
        .s_axi4s_tready  (s_axi4s_tready),
        .m_axi4s_tuser   (m_axi4s_tuser),
        .m_axi4s_tlast   (m_axi4s_tlast),
        .m_axi4s_tdata   (m_axi4s_tdata),
        .m_axi4s_tvalid  (m_axi4s_tvalid),
`ifdef VIDEO_MNIST_CLASS_VOTE_FRAME_STATS_EN
        .stat_reject_count (stat_reject_count),
        .stat_frame_count  (stat_frame_count),
`endif
        .m_axi4s_tready  (m_axi4s_tready)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [SDW-1:0] data;
        logic           user;
        logic           last;
    } beat_t;

    typedef struct {
        logic [MW-1:0] data;
        logic          user;
        logic          last;
    } result_t;

    beat_t         in_q[$];
    result_t       exp_q[$];
    logic [MW-1:0] out_log[$];
    int            cur_thr;
    int            n_vec = 0;
    int            n_err = 0;
    int            m_rej_run = 0;
    int            m_stat_rej = 0;
    int            m_stat_frames = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: count votes per class, first class with the highest count wins, below threshold rejects
    function automatic logic [MW-1:0] ref_result(input logic [SDW-1:0] d, input int thr);
        int best;
        int win;
        logic [VB-1:0] grp;
        best = -1;
        win  = 0;
        for (int c = 0; c < CN; c++) begin
            grp = d[c*VB +: VB];
            if ($countones(grp) > best) begin
                best = $countones(grp);
                win  = c;
            end
        end
        if (best < thr) win = CN;
        return MW'(best * (1 << CW) + win);
    endfunction

    function automatic logic [SDW-1:0] rand_votes();
        logic [SDW-1:0] d;
        for (int c = 0; c < CN; c++) begin
            case ($urandom_range(4))
                0: d[c*VB +: VB] = 8'h00;
                1: d[c*VB +: VB] = 8'h0F;
                2: d[c*VB +: VB] = 8'hF0;
                3: d[c*VB +: VB] = 8'hFF;
                default: d[c*VB +: VB] = VB'($urandom);
            endcase
        end
        return d;
    endfunction

    function automatic logic [SDW-1:0] fill_votes(input logic [VB-1:0] v);
        logic [SDW-1:0] d;
        for (int c = 0; c < CN; c++) d[c*VB +: VB] = v;
        return d;
    endfunction

    task automatic push_beat(input logic [SDW-1:0] d, input logic u, input logic l);
        beat_t b;
        b.data = d;
        b.user = u;
        b.last = l;
        in_q.push_back(b);
    endtask

    // Drive queued beats, randomly throttle both sides, score every output against the model
    task automatic run(input int ready_pct, input int valid_pct, input int budget);
        int            cyc = 0;
        logic          prev_stall = 1'b0;
        logic [MW-1:0] prev_data = '0;
        result_t       e;
        while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
            @(negedge aclk);
            if (in_q.size() > 0 && $urandom_range(99) < valid_pct) begin
                s_axi4s_tvalid = 1'b1;
                s_axi4s_tdata  = in_q[0].data;
                s_axi4s_tuser  = in_q[0].user;
                s_axi4s_tlast  = in_q[0].last;
            end else begin
                s_axi4s_tvalid = 1'b0;
            end
            m_axi4s_tready = ($urandom_range(99) < ready_pct);
            #1;
            if (prev_stall) begin
                check("hold_valid", m_axi4s_tvalid, 1);
                check("hold_data", m_axi4s_tdata, prev_data);
            end
`ifdef VIDEO_MNIST_CLASS_VOTE_FRAME_STATS_EN
            check("stat_reject_count", stat_reject_count, m_stat_rej);
            check("stat_frame_count", stat_frame_count, m_stat_frames);
`endif
            if (s_axi4s_tvalid && s_axi4s_tready) begin
                e.data = ref_result(in_q[0].data, cur_thr);
                e.user = in_q[0].user;
                e.last = in_q[0].last;
                exp_q.push_back(e);
                void'(in_q.pop_front());
            end
            if (m_axi4s_tvalid && m_axi4s_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", m_axi4s_tvalid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", m_axi4s_tdata, e.data);
                    check("out_tuser", m_axi4s_tuser, e.user);
                    check("out_tlast", m_axi4s_tlast, e.last);
                    out_log.push_back(m_axi4s_tdata);
                    if (e.user) begin
                        m_stat_rej    = m_rej_run;
                        m_rej_run     = (e.data[CW-1:0] == CW'(CN)) ? 1 : 0;
                        m_stat_frames = m_stat_frames + 1;
                    end else if (e.data[CW-1:0] == CW'(CN)) begin
                        m_rej_run = m_rej_run + 1;
                    end
                end
            end
            prev_stall = m_axi4s_tvalid && !m_axi4s_tready;
            prev_data  = m_axi4s_tdata;
            cyc++;
        end
        check("drain_left", in_q.size() + exp_q.size(), 0);
        @(negedge aclk);
        s_axi4s_tvalid = 1'b0;
        m_axi4s_tready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            edges;
        int            acc;
        logic [SDW-1:0] d;

        // Reset state
        repeat (3) @(negedge aclk);
        #1;
        check("rst_m_tvalid", m_axi4s_tvalid, 0);
        check("rst_m_tdata", m_axi4s_tdata, 0);
        check("rst_m_tuser", m_axi4s_tuser, 0);
        check("rst_m_tlast", m_axi4s_tlast, 0);
        check("rst_s_tready", s_axi4s_tready, 0);
        @(negedge aclk);
        aresetn = 1'b1;

        // Class 3 strong, threshold 5: latency and value
        cur_thr = 5;
        param_threshold = SW'(cur_thr);
        d = fill_votes(8'h0F);
        d[3*VB +: VB] = 8'hFF;
        @(negedge aclk);
        s_axi4s_tvalid = 1'b1;
        s_axi4s_tdata  = d;
        s_axi4s_tuser  = 1'b0;
        s_axi4s_tlast  = 1'b1;
        m_axi4s_tready = 1'b1;
        #1;
        check("lat_s_tready", s_axi4s_tready, 1);
        @(posedge aclk);
        edges = 1;
        @(negedge aclk);
        s_axi4s_tvalid = 1'b0;
        #1;
        while (!m_axi4s_tvalid && edges < 10) begin
            @(posedge aclk);
            edges++;
            @(negedge aclk);
            #1;
        end
        check("latency_edges", edges, 3);
        check("class3_data", m_axi4s_tdata, 8'h83);
        check("class3_tlast", m_axi4s_tlast, 1);

        // Tie between classes 2 and 7 goes to class 2
        cur_thr = 1;
        param_threshold = SW'(cur_thr);
        d = fill_votes(8'h00);
        d[2*VB +: VB] = 8'hF0;
        d[7*VB +: VB] = 8'hF0;
        push_beat(d, 1'b0, 1'b0);
        run(100, 100, 50);
        check("tie_data", out_log[out_log.size()-1], 8'h42);

        // Everything scores 2, threshold 3: reject
        cur_thr = 3;
        param_threshold = SW'(cur_thr);
        push_beat(fill_votes(8'h03), 1'b0, 1'b0);
        run(100, 100, 50);
        check("reject_data", out_log[out_log.size()-1], 8'h2A);

        // All-zero votes with threshold 0 and 1
        cur_thr = 0;
        param_threshold = '0;
        push_beat(fill_votes(8'h00), 1'b0, 1'b0);
        run(100, 100, 50);
        check("zero_thr0", out_log[out_log.size()-1], 8'h00);
        cur_thr = 1;
        param_threshold = SW'(cur_thr);
        push_beat(fill_votes(8'h00), 1'b0, 1'b0);
        run(100, 100, 50);
        check("zero_thr1", out_log[out_log.size()-1], 8'h0A);

        // Randomized bursts under random backpressure
        for (int burst = 0; burst < 6; burst++) begin
            cur_thr = $urandom_range(8);
            param_threshold = SW'(cur_thr);
            for (int i = 0; i < 20; i++) begin
                push_beat(rand_votes(), 1'($urandom), 1'($urandom));
            end
            run(50, 80, 400);
        end

        // Reset while three beats are stalled in the pipeline
        cur_thr = 2;
        param_threshold = SW'(cur_thr);
        acc = 0;
        for (int i = 0; i < 10 && acc < 3; i++) begin
            @(negedge aclk);
            m_axi4s_tready = 1'b0;
            s_axi4s_tvalid = 1'b1;
            s_axi4s_tdata  = rand_votes();
            s_axi4s_tuser  = 1'b1;
            s_axi4s_tlast  = 1'b1;
            #1;
            if (s_axi4s_tready) acc++;
        end
        @(negedge aclk);
        s_axi4s_tvalid = 1'b0;
        #1;
        check("stall_accepted", acc, 3);
        check("stall_tvalid", m_axi4s_tvalid, 1);
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check("midrst_m_tvalid", m_axi4s_tvalid, 0);
        check("midrst_m_tdata", m_axi4s_tdata, 0);
        check("midrst_m_tuser", m_axi4s_tuser, 0);
        check("midrst_s_tready", s_axi4s_tready, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        exp_q.delete();
        m_rej_run = 0;
        m_stat_rej = 0;
        m_stat_frames = 0;
        d = fill_votes(8'h01);
        d[9*VB +: VB] = 8'h07;
        push_beat(d, 1'b0, 1'b1);
        run(100, 100, 50);
        check("post_reset_first", out_log[out_log.size()-1], 8'h39);

        // Two frames of 16 beats, five rejects in the first
        cur_thr = 1;
        param_threshold = SW'(cur_thr);
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 16; i++) begin
                if (f == 0 && (i == 2 || i == 5 || i == 7 || i == 11 || i == 15)) begin
                    d = fill_votes(8'h00);
                end else begin
                    d = rand_votes() | SDW'(1);
                end
                push_beat(d, (i == 0), (i == 15));
            end
        end
        run(70, 90, 300);
`ifdef VIDEO_MNIST_CLASS_VOTE_FRAME_STATS_EN
        check("frame_reject_count", stat_reject_count, 5);
        check("frame_count", stat_frame_count, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/video_mnist_class_vote.md
Name: video_mnist_class_vote

Overview:
- Parametrised output stage placed directly after the final CNN layer of the MNIST video pipeline.
- Each input beat carries CLASS_NUM groups of VOTE_BITS binary-modulated votes. The block popcounts each group, selects the winning class, and applies a runtime confidence threshold.
- Emits one {class, score} result per pixel on AXI4-Stream, with fixed latency and full backpressure support.
- Generalises the former fixed 10x8-bit output to any class count, vote depth and reject mode.

Parameters:
- TUSER_WIDTH, 1: sideband width, passed through unchanged.
- CLASS_NUM, 10: number of classes (2..64).
- VOTE_BITS, 8: modulation votes per class (1..255).
- S_TDATA_WIDTH, CLASS_NUM*VOTE_BITS: input data width.
- SCORE_WIDTH, $clog2(VOTE_BITS+1): popcount width.
- CLASS_WIDTH, $clog2(CLASS_NUM+1): class index width; index CLASS_NUM encodes reject.
- M_TDATA_WIDTH, CLASS_WIDTH+SCORE_WIDTH: output data width.

Ports:
- aclk, in, 1: sole clock.
- aresetn, in, 1: asynchronous active-low reset.
- param_threshold, in, SCORE_WIDTH: minimum winning score for a valid class. Sampled per beat in stage 2.
- s_axi4s_tuser, in, TUSER_WIDTH: tuser[0] = frame start.
- s_axi4s_tlast, in, 1: line end.
- s_axi4s_tdata, in, S_TDATA_WIDTH: class c occupies bits [c*VOTE_BITS +: VOTE_BITS].
- s_axi4s_tvalid, in, 1: input valid.
- s_axi4s_tready, out, 1: input ready.
- m_axi4s_tuser, out, TUSER_WIDTH: delayed tuser.
- m_axi4s_tlast, out, 1: delayed tlast.
- m_axi4s_tdata, out, M_TDATA_WIDTH: {score[SCORE_WIDTH-1:0], class[CLASS_WIDTH-1:0]}, with class in the LSBs.
- m_axi4s_tvalid, out, 1: output valid.
- m_axi4s_tready, in, 1: output ready.

Behaviour:
- Reset is asynchronous and active-low on aresetn, single clock aclk. While aresetn=0, all stage valids, m_axi4s_tvalid, tdata, tuser and tlast are 0. s_axi4s_tready = 0 during reset.
- Pipeline is 3 register stages gated by cke = m_axi4s_tready | ~m_axi4s_tvalid. s_axi4s_tready = cke.
- Latency is 3 cycles from input handshake to m_axi4s_tvalid when unstalled. Throughput is 1 beat/cycle.
- A bubble (stage valid=0) advances when cke=1. When cke=0, all stages hold; no beat is dropped or duplicated.
- Stage 1: per-class popcount, SCORE_WIDTH bits each, registered with tuser, tlast and valid.
- Stage 2: argmax over the CLASS_NUM scores. Ties go to the lowest index. Registers the winning index, max score, and the threshold comparison result (reject = max_score < param_threshold).
- Stage 3: if reject, class = CLASS_NUM; otherwise class = winning index. Score is always the raw max score.
- All-zero votes give score 0. With threshold 0, the result is class 0, score 0. With threshold ≥1, the result is reject.
- param_threshold may change at any cycle. Each beat uses the value present when it is captured into stage 2.
- tuser and tlast are never modified, merged or reordered.
- Reset mid-stall discards all in-flight beats. The first post-reset output is the first beat accepted after reset release.
- m_axi4s_tvalid must not drop while m_axi4s_tready=0.

Optional Feature:
- Macro: VIDEO_MNIST_CLASS_VOTE_FRAME_STATS_EN.
- When defined, adds two output ports, both reset to 0:
  - stat_reject_count (32-bit): number of reject results in the last completed frame.
  - stat_frame_count (32-bit): number of frames seen.
- An internal counter increments on each output handshake with class==CLASS_NUM.
- On an output handshake with m_axi4s_tuser[0]=1:
  - stat_reject_count latches the running count, excluding the current beat.
  - The running counter restarts at 0, or 1 if the current beat is a reject.
  - stat_frame_count increments; it wraps at 2^32.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package video_mnist_pkg holds:
  - the CLASS_NUM and VOTE_BITS defaults;
  - score and class width functions, based on $clog2;
  - the reject-code constant function.
- One sub-module, video_mnist_popcount: combinational popcount of VOTE_BITS bits producing SCORE_WIDTH bits. It is instantiated CLASS_NUM times in stage 1.
- The argmax stays inline, as a loop with strict greater-than comparison.

Test Plan:
- Class 3 votes 0xFF, all others 0x0F, threshold 5: output class=3, score=8, 3 cycles after the handshake.
- Classes 2 and 7 both 0xF0 (score 4), others 0, threshold 1: output class=2, score=4 (lowest index wins the tie).
- All classes 0x03, threshold 3: output class=10 (reject), score=2.
- 20-beat burst with m_axi4s_tready toggling randomly: all 20 results are in order, none lost or duplicated, and tuser/tlast stay aligned. tvalid is held while tready=0.
- aresetn pulsed low for 1 cycle while 3 beats are stalled: outputs go to 0 immediately, and the next output is the first post-reset beat.
- With VIDEO_MNIST_CLASS_VOTE_FRAME_STATS_EN: 2 frames of 16 beats each, 5 rejects in frame 1. At the frame 2 start handshake, stat_reject_count=5 and stat_frame_count=2.
